// File: rtl/famicom_pkg.sv
// Shared types and constants for the Famicom controller-link sequencer.
package famicom_pkg;

    // Link sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCHED = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } fc_state_t;

    // Width of bit_index: holds 0..MAX_STREAM inclusive.
    localparam int BIT_IDX_W = 6;

    // Longest stream: four pads plus the signature byte.
    localparam int MAX_STREAM = 40;

    // Signature byte a multitap adapter reports after the pad bytes.
    localparam logic [7:0] SIG_BYTE_DEFAULT = 8'h10;

endpackage

// File: rtl/famicom_edge_sync.sv
// Two-flop synchroniser for one link pin, followed by an edge register.
// level/rise/fall are all derived from the synchronised copy, so a pin
// edge shows up on rise/fall two clk_sys edges after it happens.
module famicom_edge_sync (
    input  logic clk_sys,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    // Synchroniser chain plus the previous-value register used for edge detection.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= din;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign level = sync_2;
    assign rise  = sync_2 & ~sync_prev;
    assign fall  = ~sync_2 & sync_prev;

endmodule

// File: rtl/famicom_pad_scheduler.sv
// Famicom serial controller-link sequencer. On latch it snapshots the
// enabled pad words (keyboard merged into pad 0) plus an optional multitap
// signature into a flat bit stream, then presents one bit per pulse edge.
module famicom_pad_scheduler
    import famicom_pkg::*;
#(
    parameter int         NUM_PADS       = 4,
    parameter int         MULTITAP       = 1,
    parameter logic [7:0] SIG_BYTE       = SIG_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 2000000
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [NUM_PADS*8-1:0] pad_bits,
    input  logic [NUM_PADS-1:0]   pad_en,
    input  logic [7:0]            kbd_bits,
    input  logic                  kbd_valid,
    input  logic                  famicom_latch,
    input  logic                  famicom_pulse,
    output logic                  famicom_data,
    output logic [BIT_IDX_W-1:0]  bit_index,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  link_timeout,
    output logic [1:0]            fsm_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic latch_level;
    logic latch_rise;
    logic latch_fall;
    logic pulse_level;
    logic pulse_rise;
    logic pulse_fall;

    famicom_edge_sync u_latch_sync (
        .clk_sys (clk_sys),
        .reset   (reset),
        .din     (famicom_latch),
        .level   (latch_level),
        .rise    (latch_rise),
        .fall    (latch_fall)
    );

    famicom_edge_sync u_pulse_sync (
        .clk_sys (clk_sys),
        .reset   (reset),
        .din     (famicom_pulse),
        .level   (pulse_level),
        .rise    (pulse_rise),
        .fall    (pulse_fall)
    );

    fc_state_t             state;
    fc_state_t             state_n;
    logic [BIT_IDX_W-1:0]  idx_n;
    logic                  done_n;
    logic                  load_snap;
    logic [MAX_STREAM-1:0] stream_live;
    logic [BIT_IDX_W-1:0]  len_live;
    logic [MAX_STREAM-1:0] snap;
    logic [BIT_IDX_W-1:0]  len_q;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_n;

    // Pack the enabled pad words in ascending order, then the signature byte.
    always_comb begin
        logic [BIT_IDX_W-1:0] pos;
        logic [7:0]           eff;
        stream_live = '0;
        pos         = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            eff = pad_bits[i*8 +: 8];
            if (i == 0 && kbd_valid) begin
                eff = eff | kbd_bits;
            end
            if (pad_en[i]) begin
                stream_live[pos +: 8] = eff;
                pos = pos + 6'd8;
            end
        end
        if (MULTITAP != 0) begin
            stream_live[pos +: 8] = SIG_BYTE;
            pos = pos + 6'd8;
        end
        len_live = pos;
    end

    // Next-state logic: a latch rise always wins, pulses only count in SHIFT.
    always_comb begin
        state_n   = state;
        idx_n     = bit_index;
        done_n    = 1'b0;
        load_snap = 1'b0;
        if (latch_rise) begin
            state_n   = LATCHED;
            idx_n     = '0;
            load_snap = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_n = IDLE;
                end
                LATCHED: begin
                    idx_n = '0;
                    if (latch_fall) begin
                        // Keep the snapshot taken on the last latch-high cycle.
                        if (len_q == '0) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = SHIFT;
                        end
                    end else begin
                        load_snap = 1'b1;
                    end
                end
                SHIFT: begin
                    if (pulse_rise) begin
                        idx_n = bit_index + 6'd1;
                        if (idx_n == len_q) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_n = DONE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, index, snapshot and frame_done registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            bit_index  <= '0;
            frame_done <= 1'b0;
            snap       <= '0;
            len_q      <= '0;
        end else begin
            state      <= state_n;
            bit_index  <= idx_n;
            frame_done <= done_n;
            if (load_snap) begin
                snap  <= stream_live;
                len_q <= len_live;
            end
        end
    end

    // Timeout counter: cleared by a latch rise, otherwise counts up and saturates.
    always_comb begin
        if (latch_rise) begin
            cnt_n = '0;
        end else if (cnt == CNT_MAX) begin
            cnt_n = cnt;
        end else begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    // Counter and registered timeout flag, flag tracks the counter value exactly.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt          <= '0;
            link_timeout <= 1'b0;
        end else begin
            cnt          <= cnt_n;
            link_timeout <= (cnt_n == CNT_MAX);
        end
    end

    // The levels and the pulse fall edge are not needed by the sequencer.
    logic unused_sync;
    assign unused_sync = latch_level ^ pulse_level ^ pulse_fall;

    assign famicom_data = (state == LATCHED || state == SHIFT) ? snap[bit_index] : 1'b0;
    assign busy         = (state == LATCHED || state == SHIFT);
    assign fsm_state    = state;

endmodule
